// File: rtl/multicycle_control_fsm.sv
// Main controller for the multicycle RV32 subset core: sequences the shared ALU,
// memory port and register file, with a memory ready handshake on every access.
module multicycle_control_fsm #(
    parameter int unsigned CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [6:0]       opcode,
    input  logic             zero,
    input  logic             mem_ready,
    output logic             mem_req,
    output logic             memWrite,
    output logic             adrSrc,
    output logic             irWrite,
    output logic             pcWrite,
    output logic             regWrite,
    output logic [1:0]       aluSrcA,
    output logic [1:0]       aluSrcB,
    output logic [2:0]       immSrc,
    output logic [1:0]       resultSrc,
    output logic [1:0]       aluOp,
    output logic             instr_done,
    output logic             illegal_op,
    output logic [CNT_W-1:0] instret
);

    localparam int unsigned OP_W = 7;

    localparam logic [OP_W-1:0] OP_LW   = 7'b0000011;
    localparam logic [OP_W-1:0] OP_SW   = 7'b0100011;
    localparam logic [OP_W-1:0] OP_RTYP = 7'b0110011;
    localparam logic [OP_W-1:0] OP_ITYP = 7'b0010011;
    localparam logic [OP_W-1:0] OP_BEQ  = 7'b1100011;
    localparam logic [OP_W-1:0] OP_JAL  = 7'b1101111;
    localparam logic [OP_W-1:0] OP_LUI  = 7'b0110111;

    typedef enum logic [3:0] {
        S_IDLE,
        S_FETCH,
        S_DECODE,
        S_MEMADR,
        S_MEMREAD,
        S_MEMWB,
        S_MEMWRITE,
        S_EXECR,
        S_EXECI,
        S_ALUWB,
        S_BEQ,
        S_JAL,
        S_LUI
    } state_e;

    state_e             state_q, state_d;
    logic               illegal_op_q, illegal_op_d;
    logic [CNT_W-1:0]   instret_q, instret_d;

    // State, sticky illegal flag and retired-instruction counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            illegal_op_q <= 1'b0;
            instret_q    <= '0;
        end else begin
            state_q      <= state_d;
            illegal_op_q <= illegal_op_d;
            instret_q    <= instret_d;
        end
    end

    // Next-state and Moore control decode; mem_ready only matters in memory states
    always_comb begin
        state_d      = state_q;
        illegal_op_d = illegal_op_q;
        mem_req      = 1'b0;
        memWrite     = 1'b0;
        adrSrc       = 1'b0;
        irWrite      = 1'b0;
        pcWrite      = 1'b0;
        regWrite     = 1'b0;
        aluSrcA      = 2'b00;
        aluSrcB      = 2'b00;
        immSrc       = 3'b000;
        resultSrc    = 2'b00;
        aluOp        = 2'b00;
        instr_done   = 1'b0;

        case (state_q)
            S_IDLE: begin
                state_d = S_FETCH;
            end
            S_FETCH: begin
                mem_req   = 1'b1;
                aluSrcB   = 2'b10;
                resultSrc = 2'b10;
                if (mem_ready) begin
                    irWrite = 1'b1;
                    pcWrite = 1'b1;
                    state_d = S_DECODE;
                end
            end
            S_DECODE: begin
                // Branch/jump target is precomputed here into ALUOut
                aluSrcA = 2'b01;
                aluSrcB = 2'b01;
                if (opcode == OP_BEQ) begin
                    immSrc = 3'b010;
                end else if (opcode == OP_JAL) begin
                    immSrc = 3'b011;
                end
                case (opcode)
                    OP_LW, OP_SW: state_d = S_MEMADR;
                    OP_RTYP:      state_d = S_EXECR;
                    OP_ITYP:      state_d = S_EXECI;
                    OP_BEQ:       state_d = S_BEQ;
                    OP_JAL:       state_d = S_JAL;
                    OP_LUI:       state_d = S_LUI;
                    default: begin
                        state_d      = S_FETCH;
                        illegal_op_d = 1'b1;
                    end
                endcase
            end
            S_MEMADR: begin
                aluSrcA = 2'b10;
                aluSrcB = 2'b01;
                if (opcode == OP_SW) begin
                    immSrc  = 3'b001;
                    state_d = S_MEMWRITE;
                end else begin
                    state_d = S_MEMREAD;
                end
            end
            S_MEMREAD: begin
                mem_req = 1'b1;
                adrSrc  = 1'b1;
                if (mem_ready) begin
                    state_d = S_MEMWB;
                end
            end
            S_MEMWB: begin
                resultSrc  = 2'b01;
                regWrite   = 1'b1;
                instr_done = 1'b1;
                state_d    = S_FETCH;
            end
            S_MEMWRITE: begin
                mem_req  = 1'b1;
                memWrite = 1'b1;
                adrSrc   = 1'b1;
                if (mem_ready) begin
                    instr_done = 1'b1;
                    state_d    = S_FETCH;
                end
            end
            S_EXECR: begin
                aluSrcA = 2'b10;
                aluOp   = 2'b10;
                state_d = S_ALUWB;
            end
            S_EXECI: begin
                aluSrcA = 2'b10;
                aluSrcB = 2'b01;
                aluOp   = 2'b10;
                state_d = S_ALUWB;
            end
            S_ALUWB: begin
                regWrite   = 1'b1;
                instr_done = 1'b1;
                state_d    = S_FETCH;
            end
            S_BEQ: begin
                aluSrcA    = 2'b10;
                aluOp      = 2'b01;
                pcWrite    = zero;
                instr_done = 1'b1;
                state_d    = S_FETCH;
            end
            S_JAL: begin
                // PC takes the target; oldPC+4 is formed here for rd in ALUWB
                aluSrcA = 2'b01;
                aluSrcB = 2'b10;
                immSrc  = 3'b011;
                pcWrite = 1'b1;
                state_d = S_ALUWB;
            end
            S_LUI: begin
                immSrc     = 3'b100;
                resultSrc  = 2'b11;
                regWrite   = 1'b1;
                instr_done = 1'b1;
                state_d    = S_FETCH;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        instret_d = instr_done ? instret_q + CNT_W'(1) : instret_q;
    end

    assign illegal_op = illegal_op_q;
    assign instret    = instret_q;

endmodule

// File: doc/multicycle_control_fsm.md
Name: multicycle_control_fsm

Overview:
- Moore-style main controller for the multicycle RV32 subset core: LW, SW, BEQ, JAL, I-type ALU, R-type ALU and LUI.
- Sequences a single shared ALU, the instruction/data memory port and the register file across FETCH/DECODE/EXECUTE/WRITEBACK states.
- Adds a memory ready handshake so memory accesses may stall.
- Sits beside the ALU decoder, which consumes aluOp.

Parameters:
CNT_W, 32, width of the retired-instruction counter instret.

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
opcode  in  7  instr[6:0] from the instruction register; valid from DECODE onward
zero  in  1  ALU zero flag
mem_ready  in  1  memory completes the current request this cycle
mem_req  out  1  memory access request (level, held until mem_ready)
memWrite  out  1  store strobe, qualifies mem_req
adrSrc  out  1  memory address: 0 = PC, 1 = ALUOut
irWrite  out  1  load the instruction register and oldPC
pcWrite  out  1  PC write enable (already OR-ed with branch&zero)
regWrite  out  1  register file write enable
aluSrcA  out  2  00 = PC, 01 = oldPC, 10 = rs1
aluSrcB  out  2  00 = rs2, 01 = immExt, 10 = constant 4
immSrc  out  3  000 = I, 001 = S, 010 = B, 011 = J, 100 = U
resultSrc  out  2  00 = ALUOut, 01 = read data, 10 = ALUResult, 11 = immExt
aluOp  out  2  00 = add, 01 = subtract (compare), 10 = funct-decoded
instr_done  out  1  one-cycle pulse when an instruction retires
illegal_op  out  1  sticky flag: an unsupported opcode was decoded
instret  out  CNT_W  count of retired instructions

Behaviour:
- States: IDLE, FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXECR, EXECI, ALUWB, BEQ, JAL, LUI.
- State register, illegal_op and instret reset asynchronously on rst_n=0 to IDLE, 0 and 0.
- IDLE drives every output to 0. IDLE -> FETCH unconditionally.
- Outputs are 0 unless listed for a state below.
- FETCH: mem_req=1, adrSrc=0, aluSrcA=00, aluSrcB=10, aluOp=00, resultSrc=10.
  - If mem_ready: irWrite=1, pcWrite=1 (same cycle), next state DECODE.
  - Otherwise hold FETCH with no PC/IR write.
- DECODE: aluSrcA=01, aluSrcB=01, aluOp=00 (target -> ALUOut). immSrc = 010 if BEQ, 011 if JAL, else 000.
  - Next state by opcode: 0000011 or 0100011 -> MEMADR; 0110011 -> EXECR; 0010011 -> EXECI; 1100011 -> BEQ; 1101111 -> JAL; 0110111 -> LUI.
  - Any other opcode -> FETCH and set illegal_op=1. Not retired; instr_done=0.
- MEMADR: aluSrcA=10, aluSrcB=01, aluOp=00, immSrc = 000 (LW) or 001 (SW). Next state MEMREAD (LW) or MEMWRITE (SW).
- MEMREAD: mem_req=1, adrSrc=1. If mem_ready -> MEMWB, else hold.
- MEMWB: resultSrc=01, regWrite=1 -> FETCH. Retires.
- MEMWRITE: mem_req=1, memWrite=1, adrSrc=1. If mem_ready -> FETCH and retire, else hold.
  - memWrite is held stable for the whole wait.
- EXECR: aluSrcA=10, aluSrcB=00, aluOp=10 -> ALUWB.
- EXECI: aluSrcA=10, aluSrcB=01, immSrc=000, aluOp=10 -> ALUWB.
- ALUWB: resultSrc=00, regWrite=1 -> FETCH. Retires (R-type, I-type and JAL).
- BEQ: aluSrcA=10, aluSrcB=00, aluOp=01, resultSrc=00, pcWrite=zero -> FETCH. Retires whether or not the branch is taken.
- JAL: aluSrcA=01, aluSrcB=10, aluOp=00, resultSrc=00, immSrc=011, pcWrite=1 -> ALUWB.
  - PC takes the target; rd receives oldPC+4 in ALUWB.
- LUI: immSrc=100, resultSrc=11, regWrite=1 -> FETCH. Retires.
- Retire cycle: instr_done=1 (combinational from state/mem_ready) and instret increments on the same clock edge.
- instret wraps from 2^CNT_W-1 to 0 with no flag.
- illegal_op stays set until reset.
- mem_ready is ignored outside FETCH, MEMREAD and MEMWRITE.
- rst_n low mid-access: mem_req drops immediately and the FSM goes to IDLE. The memory must discard the request.
- Cycles per instruction with zero wait states: LW 5, SW 4, R/I 4, BEQ 3, JAL 4, LUI 3.
  - Each wait cycle adds 1.

Test Plan:
- Reset release, mem_ready=1 tied, opcode=0010011 -> IDLE, FETCH, DECODE, EXECI, ALUWB. regWrite=1 only in ALUWB. instret=1 after the retire edge; instr_done pulses once.
- LW with mem_ready low for 2 cycles in both FETCH and MEMREAD -> FETCH held 3 cycles with pcWrite/irWrite only on the 3rd. MEMREAD held 3 cycles; MEMWB has resultSrc=01. Total 9 cycles.
- BEQ with zero=1, then BEQ with zero=0 -> pcWrite=1 and then pcWrite=0 in the BEQ state. aluOp=01 both times; instret increments by 2.
- JAL then LUI -> JAL state pcWrite=1, aluSrcB=10, then ALUWB regWrite=1. LUI has resultSrc=11, immSrc=100. Cycle counts are 4 and 3.
- opcode=1111111 -> DECODE goes to FETCH, illegal_op=1 and stays set. instret unchanged; a following SW with mem_ready=1 executes normally with memWrite=1 for 1 cycle.
- Assert rst_n=0 while in MEMWRITE waiting, and separately preload instret=2^CNT_W-1 and retire one instruction -> first case gives mem_req=0 and memWrite=0 asynchronously and state IDLE. Second case gives instret=0.
